bus_dev_port: RTL

- Per-device port adapter between one device/agent and bs_gnrtr_n_rbtr; one instance per driver index.
- TX side: a first-word-fall-through FIFO that feeds the arbiter's pndng/D_pop and consumes its pop.
- RX side: a FIFO that absorbs the arbiter's push/D_push for this device and presents data to the device.
- Replaces the behavioural FIFO currently emulated in the bench driver.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_fifo.sv | 71 +++++++
 rtl/bus_dev_port.sv | 108 ++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the bus device port slice.
//   ID_W          width of the destination ID field at the top of a packet
//   BROADCAST_ID  default destination ID meaning "all devices"
//   PKT_MAX       widest packet the helper function accepts
//   get_dest()    extracts the destination ID from a packet of width sz
package bus_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'b0000_0110;
    localparam int PKT_MAX = 64;

    typedef logic [PKT_MAX-1:0] pkt_max_t;

    // Callers zero-extend their packet to PKT_MAX bits and pass the real
    // width, so one helper serves every packet size.
    function automatic logic [ID_W-1:0] get_dest(input pkt_max_t pkt, input int sz);
        return ID_W'(pkt >> (sz - ID_W));
    endfunction

endpackage

// File: rtl/bus_fifo.sv
// bus_fifo: generic first-word-fall-through synchronous FIFO.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   wr, wr_data  write strobe and data
//   rd           read strobe (consumes the head)
//   rd_data      head entry, zero while empty
//   empty, full  status from the registered count
// A write while full is accepted only when a read happens in the same cycle.
module bus_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_wrOk;
    logic             w_rdOk;

    // A read is only meaningful when something is stored; a write needs
    // room, which a simultaneous valid read provides when full.
    assign w_rdOk = rd && !empty;
    assign w_wrOk = wr && (!full || w_rdOk);

    // Storage carries no reset: stale entries are never visible because
    // rd_data is masked while empty and the count restarts at zero.
    always_ff @(posedge clk) begin
        if (w_wrOk) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; the count is one bit wider so that
    // full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wrOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdOk) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_wrOk && !w_rdOk) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wrOk && w_rdOk) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign empty   = (r_count == '0);
    assign full    = (r_count == FULL_CNT);
    assign rd_data = empty ? '0 : r_mem[r_rdPtr];

endmodule

// File: rtl/bus_dev_port.sv
// bus_dev_port: adapter between one device and the bus arbiter.
//   clk, reset             rising-edge clock, synchronous active-high reset
//   tx_wr, tx_data         device write into the TX FIFO
//   tx_full, tx_err        TX full flag; one-cycle pulse on a rejected write
//   pndng, D_pop, pop      arbiter side of the TX FIFO (head + consume)
//   push, D_push           arbiter delivery into the RX FIFO
//   rx_rd, rx_data         device read of the RX head
//   rx_valid               RX FIFO non-empty
//   rx_drop_cnt            saturating count of packets lost to a full RX FIFO
module bus_dev_port
    import bus_pkg::*;
#(
    parameter int              pckg_sz   = 16,
    parameter int              depth     = 8,
    parameter logic [ID_W-1:0] dev_id    = 8'd0,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               tx_err,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_valid,
    output logic [7:0]         rx_drop_cnt
);

    typedef logic [pckg_sz-1:0] pkt_t;

    logic            w_selfAddr;
    logic            w_txWrEn;
    logic            w_txReject;
    logic            w_txEmpty;
    logic            w_rxEmpty;
    logic            w_rxFull;
    logic            w_rxDrop;
    pkt_t            w_dPop;
    pkt_t            w_rxData;
    logic            r_txErr;
    logic [7:0]      r_dropCnt;

    // A packet addressed to this device itself would loop back, so it is
    // refused, unless our own ID is the broadcast ID.
    assign w_selfAddr = (get_dest(PKT_MAX'(tx_data), pckg_sz) == dev_id) &&
                        (dev_id != broadcast);
    assign w_txWrEn   = tx_wr && !w_selfAddr;
    assign w_txReject = tx_wr && (w_selfAddr || (tx_full && !pop));

    // Full with a same-cycle pop is still accepted, hence pop in the term above.
    assign w_rxDrop   = push && w_rxFull && !rx_rd;

    bus_fifo #(
        .WIDTH (pckg_sz),
        .DEPTH (depth)
    ) u_txFifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (w_txWrEn),
        .wr_data (tx_data),
        .rd      (pop),
        .rd_data (w_dPop),
        .empty   (w_txEmpty),
        .full    (tx_full)
    );

    bus_fifo #(
        .WIDTH (pckg_sz),
        .DEPTH (depth)
    ) u_rxFifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (push),
        .wr_data (D_push),
        .rd      (rx_rd),
        .rd_data (w_rxData),
        .empty   (w_rxEmpty),
        .full    (w_rxFull)
    );

    // The error pulse is registered so it appears for exactly the cycle
    // after the rejected write; the drop counter sticks at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txErr   <= 1'b0;
            r_dropCnt <= '0;
        end else begin
            r_txErr <= w_txReject;
            if (w_rxDrop && (r_dropCnt != 8'hFF)) begin
                r_dropCnt <= r_dropCnt + 1'b1;
            end
        end
    end

    assign tx_err      = r_txErr;
    assign rx_drop_cnt = r_dropCnt;
    assign pndng       = !w_txEmpty;
    assign D_pop       = w_dPop;
    assign rx_valid    = !w_rxEmpty;
    assign rx_data     = w_rxData;

endmodule
